// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I load/store func3
// encodings, data width and FSM state codes.
package load_store_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } lsu_state_e;

    // True when func3 names a defined access for the given direction.
    function automatic logic f3_legal(input logic write, input logic [2:0] f3);
        if (write)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                   (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Load lane extraction: picks the byte/half at the given offset from the
// BRAM word and sign- or zero-extends it according to func3.
module load_extend
    import load_store_unit_pkg::*;
(
    input  logic [2:0]      func3,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Select the addressed lane, then extend it to the full register width.
    always_comb begin
        lane_b = 8'h00;
        case (off)
            2'd0: lane_b = word[7:0];
            2'd1: lane_b = word[15:8];
            2'd2: lane_b = word[23:16];
            2'd3: lane_b = word[31:24];
            default: lane_b = 8'h00;
        endcase
        lane_h = off[1] ? word[31:16] : word[15:0];
        case (func3)
            F3_B:    data = {{24{lane_b[7]}}, lane_b};
            F3_BU:   data = {24'h000000, lane_b};
            F3_H:    data = {{16{lane_h[15]}}, lane_h};
            F3_HU:   data = {16'h0000, lane_h};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a bram32 data port.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses are
// reported as errors instead of being silently aligned down.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_func3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  resp_valid,
    output logic [XLEN-1:0]       resp_rdata,
    output logic                  resp_err,
    output logic                  stall,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_r_enb,
    output logic                  mem_w_enb,
    output logic [3:0]            mem_w_be,
    output logic [XLEN-1:0]       mem_w_dat,
    input  logic [XLEN-1:0]       mem_r_dat
);

    localparam logic [1:0] CNT_INIT = 2'(RD_LATENCY - 1);

    lsu_state_e            state_q, state_d;
    logic                  write_q;
    logic [2:0]            func3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [XLEN-1:0]       wdata_q;
    logic                  err_q;
    logic [1:0]            cnt_q;
    logic [XLEN-1:0]       rdata_q;
    logic [XLEN-1:0]       ext_data;
    logic [ADDR_WIDTH-1:0] addr_fix;
    logic                  req_err;

    // Classify the incoming request and normalise its address.
    always_comb begin
        addr_fix = req_addr;
        req_err  = !f3_legal(req_write, req_func3);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((req_func3[1:0] == 2'b01 && req_addr[0]) ||
            (req_func3[1:0] == 2'b10 && req_addr[1:0] != 2'b00))
            req_err = 1'b1;
`else
        if (req_func3[1:0] == 2'b01)
            addr_fix[0] = 1'b0;
        else if (req_func3[1:0] == 2'b10)
            addr_fix[1:0] = 2'b00;
`endif
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (req_valid) state_d = req_err ? S_RESP : S_ACCESS;
            S_ACCESS: state_d = write_q ? S_RESP : S_WAIT;
            S_WAIT:   if (cnt_q == 2'd0) state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Request capture, read-latency counter and load data register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            write_q <= 1'b0;
            func3_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (req_valid) begin
                    write_q <= req_write;
                    func3_q <= req_func3;
                    addr_q  <= addr_fix;
                    wdata_q <= req_wdata;
                    err_q   <= req_err;
                    rdata_q <= '0;
                end
                S_ACCESS: cnt_q <= CNT_INIT;
                S_WAIT: begin
                    if (cnt_q == 2'd0) rdata_q <= ext_data;
                    else               cnt_q   <= cnt_q - 2'd1;
                end
                default: ;
            endcase
        end
    end

    load_extend u_load_extend (
        .func3 (func3_q),
        .off   (addr_q[1:0]),
        .word  (mem_r_dat),
        .data  (ext_data)
    );

    // Handshake, response and BRAM strobe outputs decoded from state.
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        stall      = (state_q == S_IDLE && req_valid) ||
                     (state_q == S_ACCESS) || (state_q == S_WAIT);
        resp_valid = (state_q == S_RESP);
        resp_err   = (state_q == S_RESP) && err_q;
        resp_rdata = (state_q == S_RESP) ? rdata_q : '0;
        mem_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        mem_r_enb  = (state_q == S_ACCESS) && !write_q;
        mem_w_enb  = (state_q == S_ACCESS) && write_q;
        mem_w_be   = 4'b0000;
        mem_w_dat  = '0;
        if (mem_w_enb) begin
            case (func3_q[1:0])
                2'b00: begin
                    mem_w_be  = 4'b0001 << addr_q[1:0];
                    mem_w_dat = {4{wdata_q[7:0]}};
                end
                2'b01: begin
                    mem_w_be  = 4'b0011 << addr_q[1:0];
                    mem_w_dat = {2{wdata_q[15:0]}};
                end
                default: begin
                    mem_w_be  = 4'b1111;
                    mem_w_dat = wdata_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a bram32 model
// (RD_LATENCY = 1).
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_func3;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall;
    logic [9:0]  mem_addr;
    logic        mem_r_enb;
    logic        mem_w_enb;
    logic [3:0]  mem_w_be;
    logic [31:0] mem_w_dat;
    logic [31:0] mem_r_dat;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(10), .RD_LATENCY(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_func3  (req_func3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .stall      (stall),
        .mem_addr   (mem_addr),
        .mem_r_enb  (mem_r_enb),
        .mem_w_enb  (mem_w_enb),
        .mem_w_be   (mem_w_be),
        .mem_w_dat  (mem_w_dat),
        .mem_r_dat  (mem_r_dat)
    );

    // bram32 model: byte-enabled write, one-cycle registered read.
    always @(posedge clk) begin
        if (mem_w_enb)
            for (int i = 0; i < 4; i++)
                if (mem_w_be[i]) mem[mem_addr[9:2]][8*i +: 8] <= mem_w_dat[8*i +: 8];
        if (mem_r_enb) mem_r_dat <= mem[mem_addr[9:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Present a request in cycle N, advance to N+1 and withdraw it.
    task automatic issue(input logic wr, input logic [2:0] f3,
                         input logic [9:0] a, input logic [31:0] wd, input string tag);
        req_valid = 1'b1;
        req_write = wr;
        req_func3 = f3;
        req_addr  = a;
        req_wdata = wd;
        #1;
        chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string tag);
        int n = 0;
        while (resp_valid !== 1'b1 && n < 12) begin
            step();
            n++;
        end
        chk({tag, "_resp_seen"}, {31'b0, resp_valid}, 32'd1);
    endtask

    task automatic do_access(input logic wr, input logic [2:0] f3, input logic [9:0] a,
                             input logic [31:0] wd, input logic [31:0] exp, input string tag);
        issue(wr, f3, a, wd, tag);
        wait_resp(tag);
        chk({tag, "_rdata"}, resp_rdata, exp);
        chk({tag, "_err"}, {31'b0, resp_err}, 32'd0);
        step();
        chk({tag, "_pulse"}, {31'b0, resp_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_func3 = 3'b000; req_addr = '0; req_wdata = '0;
        repeat (3) step();
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_strobes", {28'b0, mem_r_enb, mem_w_enb, resp_err, 1'b0}, 32'd0);
        chk("rst_mem_addr", {22'b0, mem_addr}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        rst = 1'b1;
        step();

        // Preload memory through the unit.
        do_access(1'b1, 3'b010, 10'h004, 32'h8899AABB, 32'h0, "sw_004");
        do_access(1'b1, 3'b010, 10'h00C, 32'h11223344, 32'h0, "sw_00C");

        // lw 0x004: cycle-accurate timing.
        req_valid = 1'b1; req_write = 1'b0; req_func3 = 3'b010; req_addr = 10'h004;
        #1;
        chk("lw_N_stall", {31'b0, stall}, 32'd1);
        step(); req_valid = 1'b0;
        chk("lw_N1_renb", {31'b0, mem_r_enb}, 32'd1);
        chk("lw_N1_wenb", {31'b0, mem_w_enb}, 32'd0);
        chk("lw_N1_addr", {22'b0, mem_addr}, 32'h004);
        chk("lw_N1_stall", {31'b0, stall}, 32'd1);
        step();
        chk("lw_N2_valid", {31'b0, resp_valid}, 32'd0);
        chk("lw_N2_stall", {31'b0, stall}, 32'd1);
        chk("lw_N2_ready", {31'b0, req_ready}, 32'd0);
        step();
        chk("lw_N3_valid", {31'b0, resp_valid}, 32'd1);
        chk("lw_N3_rdata", resp_rdata, 32'h8899AABB);
        chk("lw_N3_stall", {31'b0, stall}, 32'd0);
        step();
        chk("lw_N4_valid", {31'b0, resp_valid}, 32'd0);

        // Sub-word loads with extension.
        do_access(1'b0, 3'b000, 10'h007, 32'h0, 32'hFFFFFF88, "lb_007");
        do_access(1'b0, 3'b100, 10'h006, 32'h0, 32'h00000099, "lbu_006");
        do_access(1'b0, 3'b001, 10'h006, 32'h0, 32'hFFFF8899, "lh_006");
        do_access(1'b0, 3'b101, 10'h004, 32'h0, 32'h0000AABB, "lhu_004");
        do_access(1'b0, 3'b000, 10'h004, 32'h0, 32'hFFFFFFBB, "lb_004");

        // sb 0x00D: strobe timing and lane replication.
        issue(1'b1, 3'b000, 10'h00D, 32'h000000EE, "sb_00D");
        chk("sb_N1_wenb", {31'b0, mem_w_enb}, 32'd1);
        chk("sb_N1_renb", {31'b0, mem_r_enb}, 32'd0);
        chk("sb_N1_addr", {22'b0, mem_addr}, 32'h00C);
        chk("sb_N1_be", {28'b0, mem_w_be}, 32'b0010);
        chk("sb_N1_wdat", mem_w_dat, 32'hEEEEEEEE);
        step();
        chk("sb_N2_valid", {31'b0, resp_valid}, 32'd1);
        chk("sb_N2_err", {31'b0, resp_err}, 32'd0);
        chk("sb_N2_rdata", resp_rdata, 32'd0);
        step();
        do_access(1'b0, 3'b010, 10'h00C, 32'h0, 32'h1122EE44, "lw_after_sb");

        // sh 0x00E: upper half lanes.
        issue(1'b1, 3'b001, 10'h00E, 32'hCAFE1234, "sh_00E");
        chk("sh_N1_be", {28'b0, mem_w_be}, 32'b1100);
        chk("sh_N1_wdat", mem_w_dat, 32'h12341234);
        wait_resp("sh_00E");
        step();
        do_access(1'b0, 3'b010, 10'h00C, 32'h0, 32'h1234EE44, "lw_after_sh");

        // Misaligned word load.
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b0, 3'b010, 10'h006, 32'h0, "lw_006");
        chk("lw_006_valid", {31'b0, resp_valid}, 32'd1);
        chk("lw_006_err", {31'b0, resp_err}, 32'd1);
        chk("lw_006_strobes", {30'b0, mem_r_enb, mem_w_enb}, 32'd0);
        step();
`else
        do_access(1'b0, 3'b010, 10'h006, 32'h0, 32'h8899AABB, "lw_006");
`endif

        // Illegal func3.
        issue(1'b0, 3'b011, 10'h004, 32'h0, "f3_011");
        chk("f3_011_valid", {31'b0, resp_valid}, 32'd1);
        chk("f3_011_err", {31'b0, resp_err}, 32'd1);
        chk("f3_011_strobes", {30'b0, mem_r_enb, mem_w_enb}, 32'd0);
        chk("f3_011_rdata", resp_rdata, 32'd0);
        step();
        issue(1'b1, 3'b100, 10'h004, 32'h0, "sf3_100");
        chk("sf3_100_err", {30'b0, resp_valid, resp_err}, 32'b11);
        chk("sf3_100_wenb", {31'b0, mem_w_enb}, 32'd0);
        step();

        // Reset during WAIT aborts the load.
        issue(1'b0, 3'b010, 10'h004, 32'h0, "abort");
        step();
        rst = 1'b0;
        step();
        chk("abort_ready", {31'b0, req_ready}, 32'd1);
        chk("abort_valid", {31'b0, resp_valid}, 32'd0);
        chk("abort_stall", {31'b0, stall}, 32'd0);
        rst = 1'b1;
        step();
        chk("abort_after_valid", {31'b0, resp_valid}, 32'd0);

        // Request held during ACCESS/WAIT is ignored.
        issue(1'b0, 3'b010, 10'h004, 32'h0, "ignore");
        req_valid = 1'b1; req_write = 1'b1; req_func3 = 3'b010;
        req_addr = 10'h004; req_wdata = 32'hDEADBEEF;
        step();
        chk("ignore_ready", {31'b0, req_ready}, 32'd0);
        chk("ignore_wenb", {31'b0, mem_w_enb}, 32'd0);
        step();
        req_valid = 1'b0;
        chk("ignore_valid", {31'b0, resp_valid}, 32'd1);
        chk("ignore_rdata", resp_rdata, 32'h8899AABB);
        step();
        chk("ignore_idle_wenb", {31'b0, mem_w_enb}, 32'd0);
        do_access(1'b0, 3'b010, 10'h004, 32'h0, 32'h8899AABB, "ignore_mem_kept");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
